// File: rtl/flit_packetizer.sv
// ---------------------------------------------------------------------------
// flit_packetizer
//
// Network-interface transmitter feeding a router's local input port. A message
// request (destination node index + payload length) followed by a stream of
// payload words is turned into a head / body / tail flit stream.
//
// The head flit carries the destination mesh coordinates where HeadFlitDecoder
// expects them: DestY at data[0 +: RB], DestX at data[RB +: RB], all higher
// data bits zero. Flit type lives in the two MSBs of flit_data:
//    2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 head+tail (single flit).
//
// Ports:
//    clk        in   clock
//    rst        in   asynchronous active-low reset
//    msg_valid  in   message request valid
//    msg_ready  out  request accepted when msg_valid & msg_ready
//    msg_dest   in   destination node index, clog2(N) bits
//    msg_len    in   payload flits following the head, LEN_WIDTH bits
//    pay_valid  in   payload word valid
//    pay_ready  out  payload word accepted when pay_valid & pay_ready
//    pay_data   in   payload word, DATA_WIDTH bits
//    flit_valid out  registered flit valid towards the router
//    flit_ready in   router accepts the flit
//    flit_data  out  {type[1:0], data[DATA_WIDTH-1:0]}
//    err_dest   out  one-cycle pulse after accepting msg_dest >= N
//    self_send  out  one-cycle pulse after accepting msg_dest == INDEX
// ---------------------------------------------------------------------------
module flit_packetizer #(
    parameter int N          = 4,
    parameter int INDEX      = 1,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [$clog2(N)-1:0]    msg_dest,
    input  logic [LEN_WIDTH-1:0]    msg_len,
    input  logic                    pay_valid,
    output logic                    pay_ready,
    input  logic [DATA_WIDTH-1:0]   pay_data,
    output logic                    flit_valid,
    input  logic                    flit_ready,
    output logic [DATA_WIDTH+1:0]   flit_data,
    output logic                    err_dest,
    output logic                    self_send
);

    // Integer square root used to recover the mesh dimension from N.
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        for (int i = 1; i <= n; i++) begin
            if (i * i <= n) r = i;
        end
        return r;
    endfunction

    localparam int DIM = isqrt(N);
    localparam int RB  = $clog2(DIM);
    localparam int DW  = $clog2(N);

    localparam logic [DW:0]           NODES    = (DW + 1)'(N);
    localparam logic [DW-1:0]         DIM_V    = DW'(DIM);
    localparam logic [DW-1:0]         SELF_ID  = DW'(INDEX);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BODY,
        S_DROP
    } state_t;

    state_t                  r_state;
    logic                    r_flitValid;
    logic [DATA_WIDTH+1:0]   r_flitData;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic                    r_errDest;
    logic                    r_selfSend;

    logic                    w_slotFree;
    logic                    w_msgReady;
    logic                    w_payReady;
    logic                    w_msgAccept;
    logic                    w_payAccept;
    logic                    w_destOk;
    logic                    w_lastWord;
    logic [DW-1:0]           w_destY;
    logic [DW-1:0]           w_destX;
    logic [DATA_WIDTH-1:0]   w_headData;

    // The single output stage can take a new flit when it is empty or is
    // being drained this very cycle, which gives back-to-back flits.
    assign w_slotFree = !r_flitValid || flit_ready;

    // Handshake readies are gated by reset so both read low while rst is held.
    assign w_msgReady  = rst && (r_state == S_IDLE) && w_slotFree;
    assign w_payReady  = rst && (((r_state == S_BODY) && w_slotFree) || (r_state == S_DROP));
    assign w_msgAccept = msg_valid && w_msgReady;
    assign w_payAccept = pay_valid && w_payReady;

    assign w_destOk   = ({1'b0, msg_dest} < NODES);
    assign w_lastWord = (r_remaining == LEN_ONE);

    // Row-major node numbering: quotient is Y, remainder is X. Both are below
    // DIM and therefore fit in RB bits, so shifting and OR-ing the zero-extended
    // values yields exactly {0..., DestX, DestY}.
    assign w_destY    = msg_dest / DIM_V;
    assign w_destX    = msg_dest - (w_destY * DIM_V);
    assign w_headData = (DATA_WIDTH'(w_destX) << RB) | DATA_WIDTH'(w_destY);

    // Packet sequencer and output register. The flit stage clears on a drain
    // and any load in the same cycle overrides that clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_flitValid <= 1'b0;
            r_flitData  <= '0;
            r_remaining <= '0;
            r_errDest   <= 1'b0;
            r_selfSend  <= 1'b0;
        end else begin
            r_errDest  <= 1'b0;
            r_selfSend <= 1'b0;
            if (flit_ready) r_flitValid <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_msgAccept) begin
                        r_remaining <= msg_len;
                        if (w_destOk) begin
                            r_flitValid <= 1'b1;
                            r_flitData  <= {((msg_len == LEN_ZERO) ? T_SINGLE : T_HEAD), w_headData};
                            r_selfSend  <= (msg_dest == SELF_ID);
                            if (msg_len != LEN_ZERO) r_state <= S_BODY;
                        end else begin
                            // Unreachable node: swallow the payload without emitting flits.
                            r_errDest <= 1'b1;
                            if (msg_len != LEN_ZERO) r_state <= S_DROP;
                        end
                    end
                end
                S_BODY: begin
                    if (w_payAccept) begin
                        r_flitValid <= 1'b1;
                        r_flitData  <= {(w_lastWord ? T_TAIL : T_BODY), pay_data};
                        r_remaining <= r_remaining - LEN_ONE;
                        if (w_lastWord) r_state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (w_payAccept) begin
                        r_remaining <= r_remaining - LEN_ONE;
                        if (w_lastWord) r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign msg_ready  = w_msgReady;
    assign pay_ready  = w_payReady;
    assign flit_valid = r_flitValid;
    assign flit_data  = r_flitData;
    assign err_dest   = r_errDest;
    assign self_send  = r_selfSend;

endmodule

// File: tb/tb_flit_packetizer.sv
// ---------------------------------------------------------------------------
// tb_flit_packetizer
//
// Bench for flit_packetizer on a 3x3 mesh (N=9, INDEX=1). A transaction-level
// model keeps the queue of flits the router should receive plus the number of
// payload words still owed by the current message, and derives every expected
// handshake and pulse from those. Directed steps cover the corner cases, then a
// randomized phase mixes valid/invalid destinations, lengths and back-pressure.
// ---------------------------------------------------------------------------
module tb_flit_packetizer;

    localparam int N          = 9;
    localparam int INDEX      = 1;
    localparam int DATA_WIDTH = 8;
    localparam int LEN_WIDTH  = 4;
    localparam int DIM        = 3;
    localparam int RB         = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [3:0]  msg_dest;
    logic [3:0]  msg_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  pay_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [9:0]  flit_data;
    logic        err_dest;
    logic        self_send;

    always #5 clk = ~clk;

    flit_packetizer #(
        .N          (N),
        .INDEX      (INDEX),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_dest   (msg_dest),
        .msg_len    (msg_len),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_data   (pay_data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
        .err_dest   (err_dest),
        .self_send  (self_send)
    );

    // Scoreboard and reference-model state
    int          passCnt   = 0;
    int          totalCnt  = 0;
    logic [9:0]  expQ[$];
    int          curLeft   = 0;
    bit          curSend   = 1'b0;
    int          msgsDone  = 0;
    bit          expErr    = 1'b0;
    bit          expSelf   = 1'b0;
    bit          expLoad   = 1'b0;
    bit          prevHold  = 1'b0;
    logic [9:0]  prevData  = '0;

    // One comparison: count it, and report tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accepted request: a reachable node yields a head (or single) flit with
    // row-major coordinates; an unreachable node only owes its payload words.
    task automatic modelMsg(input int dest, input int len);
        int y;
        int x;
        logic [7:0] hd;
        totalCnt++;
        assert (curLeft == 0) passCnt++;
        else $error("[TB] FAIL msg_boundary: observed remaining %0d expected 0", curLeft);
        curLeft = len;
        if (dest >= N) begin
            expErr  = 1'b1;
            curSend = 1'b0;
        end else begin
            y  = dest / DIM;
            x  = dest % DIM;
            hd = 8'((x << RB) | y);
            expQ.push_back({((len == 0) ? 2'b11 : 2'b01), hd});
            expSelf = (dest == INDEX);
            expLoad = 1'b1;
            curSend = 1'b1;
        end
        msgsDone++;
    endtask

    // Accepted payload word: the last owed word of a sent packet is the tail.
    task automatic modelPay(input logic [7:0] d);
        totalCnt++;
        assert (curLeft > 0) passCnt++;
        else $error("[TB] FAIL pay_outside_packet: observed word %0h expected none", d);
        if (curLeft > 0) begin
            if (curSend) begin
                expQ.push_back({((curLeft == 1) ? 2'b10 : 2'b00), d});
                expLoad = 1'b1;
            end
            curLeft--;
        end
    endtask

    // Drive one cycle of inputs, check handshakes before the edge and the
    // registered outputs just after it.
    task automatic applyStimulus(input logic mv, input logic [3:0] dest, input logic [3:0] len,
                                 input logic pv, input logic [7:0] pd, input logic fr);
        bit slotFree;
        bit holdNext;
        bit expMsgRdy;
        bit expPayRdy;
        logic [9:0] want;
        msg_valid  = mv;
        msg_dest   = dest;
        msg_len    = len;
        pay_valid  = pv;
        pay_data   = pd;
        flit_ready = fr;
        expErr  = 1'b0;
        expSelf = 1'b0;
        expLoad = 1'b0;
        #1;
        slotFree  = !flit_valid || flit_ready;
        expMsgRdy = (curLeft == 0) && slotFree;
        expPayRdy = (curLeft == 0) ? 1'b0 : (curSend ? slotFree : 1'b1);
        checkOutput("msg_ready", msg_ready, expMsgRdy);
        checkOutput("pay_ready", pay_ready, expPayRdy);
        if (prevHold) checkOutput("hold_data", flit_data, prevData);
        if (flit_valid && flit_ready) begin
            totalCnt++;
            assert (expQ.size() > 0) passCnt++;
            else $error("[TB] FAIL unexpected_flit: observed %0h expected none", flit_data);
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                checkOutput("flit_data", flit_data, want);
            end
        end
        holdNext = flit_valid && !flit_ready;
        prevData = flit_data;
        if (msg_valid && msg_ready) modelMsg(msg_dest, msg_len);
        if (pay_valid && pay_ready) modelPay(pay_data);
        @(posedge clk);
        #1;
        prevHold = holdNext;
        checkOutput("flit_valid", flit_valid, expLoad || holdNext);
        checkOutput("err_dest", err_dest, expErr);
        checkOutput("self_send", self_send, expSelf);
    endtask

    initial begin
        // Reset state, with requests and payload already asserted
        rst        = 1'b0;
        msg_valid  = 1'b1;
        msg_dest   = 4'd0;
        msg_len    = 4'd0;
        pay_valid  = 1'b1;
        pay_data   = 8'h11;
        flit_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_flit_valid", flit_valid, 1'b0);
        checkOutput("rst_flit_data", flit_data, 10'h000);
        checkOutput("rst_msg_ready", msg_ready, 1'b0);
        checkOutput("rst_pay_ready", pay_ready, 1'b0);
        checkOutput("rst_err_dest", err_dest, 1'b0);
        checkOutput("rst_self_send", self_send, 1'b0);
        rst = 1'b1;

        // Single-flit packet to node 7 (Y=2, X=1): one flit after one cycle
        applyStimulus(1'b1, 4'd7, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("single_data", flit_data, 10'h306);
        checkOutput("single_msg_ready_again", msg_ready, 1'b1);

        // Three-word packet back-to-back behind the single flit
        applyStimulus(1'b1, 4'd7, 4'd3, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'hAA, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'hBB, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'hCC, 1'b1);
        checkOutput("tail_data", flit_data, 10'h2CC);

        // Same style of packet under flit_ready pattern 1,0,0,1,0,0,...
        applyStimulus(1'b1, 4'd5, 4'd4, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40 && curLeft != 0; i++)
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'(8'h30 + i), (i % 3) == 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b1);

        // Self-send to INDEX with one payload word
        applyStimulus(1'b1, 4'd1, 4'd1, 1'b0, 8'h00, 1'b1);
        checkOutput("self_send_pulse", self_send, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'h55, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b1);

        // Unreachable node 9: error pulse, two words dropped, no flits
        applyStimulus(1'b1, 4'd9, 4'd2, 1'b0, 8'h00, 1'b1);
        checkOutput("err_dest_pulse", err_dest, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'hD1, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'hD2, 1'b1);
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("after_drop_data", flit_data, 10'h300);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-packet, with a body flit held in the stage
        applyStimulus(1'b1, 4'd5, 4'd3, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 8'hAA, 1'b1);
        flit_ready = 1'b0;
        pay_valid  = 1'b0;
        rst        = 1'b0;
        #1;
        checkOutput("midrst_flit_valid", flit_valid, 1'b0);
        checkOutput("midrst_flit_data", flit_data, 10'h000);
        checkOutput("midrst_pay_ready", pay_ready, 1'b0);
        expQ.delete();
        curLeft  = 0;
        prevHold = 1'b0;
        rst      = 1'b1;
        #1;
        applyStimulus(1'b1, 4'd8, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_data", flit_data, 10'h30A);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic: mixed destinations, lengths and back-pressure
        begin : randomPhase
            int cycles;
            int target;
            logic mv;
            cycles = 0;
            target = msgsDone + 40;
            while ((msgsDone < target || curLeft != 0) && cycles < 4000) begin
                mv = (curLeft == 0 && msgsDone < target) ? ($urandom_range(0, 1) == 1) : 1'b0;
                applyStimulus(mv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)),
                              $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
                cycles++;
            end
            checkOutput("random_within_budget", cycles < 4000, 1'b1);
        end

        // Drain whatever is still owed to the router
        for (int i = 0; i < 20 && expQ.size() > 0; i++)
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b1);
        checkOutput("drain_empty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
